// File: rtl/router_dest_reader_if.sv
// FIFO-read and destination-stream signal bundle for one router output port.
// master = drain engine side, slave = FIFO/destination side.
interface router_dest_reader_if;
    logic       vld_out;
    logic [7:0] data_out;
    logic       read_enb;
    logic       sink_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_sop;
    logic       out_eop;

    modport master (
        input  vld_out, data_out, sink_ready,
        output read_enb, out_data, out_valid, out_sop, out_eop
    );

    modport slave (
        output vld_out, data_out, sink_ready,
        input  read_enb, out_data, out_valid, out_sop, out_eop
    );
endinterface

// File: rtl/router_dest_reader.sv
// Destination-side drain engine: reads header/payload/parity from the port FIFO and streams payload.
// Optional macro ROUTER_PARITY_CHK_EN enables the parity accumulator and parity_err reporting.
module router_dest_reader #(
    parameter int unsigned START_DELAY   = 2,
    parameter int unsigned ABORT_TIMEOUT = 31
) (
    input  logic                        clock,
    input  logic                        reset,
    router_dest_reader_if.master        rif,
    output logic [1:0]                  pkt_addr,
    output logic [5:0]                  pkt_len,
    output logic                        pkt_done,
    output logic                        parity_err,
    output logic                        pkt_abort,
    output logic                        busy
);
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 6;
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] START_CNT  = CW'(START_DELAY);
    localparam logic [CW-1:0] ABORT_LAST = CW'(ABORT_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_t;

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] to_cnt;
    logic [LW-1:0] issued;
    logic [LW-1:0] rx_cnt;
    logic          rd_inflight;
    logic [DW-1:0] out_data_q;
    logic          out_valid_q, out_sop_q, out_eop_q;

    logic          read_enb_c;
    logic          capture_c;
    logic          to_count_c;
    logic          abort_c;
    logic [LW-1:0] hdr_len_c;

    assign hdr_len_c = rif.data_out[7:2];

    // The read strobe must track vld_out in the same cycle, so it is decoded, not registered.
    assign rif.read_enb  = read_enb_c & ~reset;
    assign rif.out_data  = out_data_q;
    assign rif.out_valid = out_valid_q;
    assign rif.out_sop   = out_sop_q;
    assign rif.out_eop   = out_eop_q;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state, read issue, capture and timeout decode.
    always_comb begin
        state_next = state;
        read_enb_c = 1'b0;
        capture_c  = 1'b0;
        to_count_c = 1'b0;
        abort_c    = 1'b0;
        case (state)
            IDLE: begin
                // pkt_done/pkt_abort high marks the mandatory one-cycle gap before a new header.
                if (rif.vld_out && !pkt_done && !pkt_abort && (wait_cnt == START_CNT)) begin
                    read_enb_c = 1'b1;
                    state_next = HEADER;
                end
            end
            HEADER: begin
                capture_c = rd_inflight;
                if (rd_inflight)
                    state_next = (hdr_len_c == '0) ? PARITY : PAYLOAD;
            end
            PAYLOAD: begin
                read_enb_c = rif.vld_out && rif.sink_ready && !rd_inflight && (issued < pkt_len);
                capture_c  = rd_inflight;
                if (rd_inflight && (rx_cnt == pkt_len - LW'(1)))
                    state_next = PARITY;
            end
            PARITY: begin
                read_enb_c = rif.vld_out && !rd_inflight;
                capture_c  = rd_inflight;
                if (rd_inflight)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (state != IDLE) begin
            to_count_c = !rif.vld_out && !rd_inflight;
            if (to_count_c && (to_cnt == ABORT_LAST)) begin
                abort_c    = 1'b1;
                state_next = IDLE;
            end
        end
    end

    // Counters, read tracking and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt    <= '0;
            to_cnt      <= '0;
            issued      <= '0;
            rx_cnt      <= '0;
            rd_inflight <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            pkt_addr    <= '0;
            pkt_len     <= '0;
            pkt_done    <= 1'b0;
            pkt_abort   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            pkt_done    <= 1'b0;
            pkt_abort   <= abort_c;
            busy        <= (state_next != IDLE);
            rd_inflight <= read_enb_c;

            if ((state != IDLE) || !rif.vld_out || pkt_done || pkt_abort || read_enb_c)
                wait_cnt <= '0;
            else if (wait_cnt != START_CNT)
                wait_cnt <= wait_cnt + CW'(1);

            if ((state == IDLE) || capture_c || abort_c || !to_count_c)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + CW'(1);

            if (state != PAYLOAD)
                issued <= '0;
            else if (read_enb_c)
                issued <= issued + LW'(1);

            if (capture_c) begin
                case (state)
                    HEADER: begin
                        pkt_len  <= hdr_len_c;
                        pkt_addr <= rif.data_out[1:0];
                        rx_cnt   <= '0;
                    end
                    PAYLOAD: begin
                        out_data_q  <= rif.data_out;
                        out_valid_q <= 1'b1;
                        out_sop_q   <= (rx_cnt == '0);
                        out_eop_q   <= (rx_cnt == pkt_len - LW'(1));
                        rx_cnt      <= rx_cnt + LW'(1);
                    end
                    PARITY:  pkt_done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef ROUTER_PARITY_CHK_EN
    logic [DW-1:0] acc;

    // Running XOR of header and payload, compared against the trailing parity byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc        <= '0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            if (capture_c) begin
                case (state)
                    HEADER:  acc        <= rif.data_out;
                    PAYLOAD: acc        <= acc ^ rif.data_out;
                    PARITY:  parity_err <= (acc != rif.data_out);
                    default: ;
                endcase
            end
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_dest_reader.sv
// Bench for router_dest_reader: FIFO/destination model plus a packet-level reference queue.
module tb_router_dest_reader;
    localparam int unsigned START_DELAY   = 2;
    localparam int unsigned ABORT_TIMEOUT = 31;
`ifdef ROUTER_PARITY_CHK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] pkt_addr;
    logic [5:0] pkt_len;
    logic       pkt_done, parity_err, pkt_abort, busy;

    router_dest_reader_if rif();

    router_dest_reader #(
        .START_DELAY  (START_DELAY),
        .ABORT_TIMEOUT(ABORT_TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rif       (rif),
        .pkt_addr  (pkt_addr),
        .pkt_len   (pkt_len),
        .pkt_done  (pkt_done),
        .parity_err(parity_err),
        .pkt_abort (pkt_abort),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: FIFO contents and expected beats / packet completions.
    logic [7:0] fq[$];
    logic [9:0] exp_beats[$];   // {sop, eop, data}
    logic [8:0] exp_done[$];    // {parity_err, len, addr}
    int  n_pushed = 0;
    bit  gate = 1'b1;
    bit  sink_cmd = 1'b1;
    bit  rnd_mode = 1'b0;

    // Monitor-side state
    int  cyc = 0, n_reads = 0, n_beats = 0, n_done = 0, n_abort = 0;
    int  last_rd_cyc = 0, rise_neg = 0;
    int  beat_cyc[$];
    bit  rd_q = 1'b0, prev_rd = 1'b0;
    logic [9:0] mb;
    logic [8:0] md;

    // FIFO and destination driver: pops on the read sampled at the edge just passed.
    bit rgate, vld_n;
    always @(posedge clock) begin
        #1;
        if (rd_q && fq.size() != 0) rif.data_out = fq.pop_front();
        rgate = ($urandom_range(0, 4) != 0);
        rif.sink_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : sink_cmd;
        vld_n = (rnd_mode ? rgate : gate) && (fq.size() != 0);
        if (vld_n && (rif.vld_out !== 1'b1)) rise_neg = cyc + 1;
        rif.vld_out = vld_n;
    end

    always @(negedge clock) begin
        cyc++;
        rd_q = rif.read_enb;
        if (rif.read_enb) begin
            n_reads++;
            last_rd_cyc = cyc;
            check("rd_back_to_back", 32'(prev_rd), 0);
            check("rd_when_empty", 32'(rif.vld_out), 1);
        end
        prev_rd = rif.read_enb;
        if (rif.out_valid) begin
            n_beats++;
            beat_cyc.push_back(cyc);
            if (exp_beats.size() == 0) check("beat_unexpected", 1, 0);
            else begin
                mb = exp_beats.pop_front();
                check("beat_data", 32'(rif.out_data), 32'(mb[7:0]));
                check("beat_sop", 32'(rif.out_sop), 32'(mb[9]));
                check("beat_eop", 32'(rif.out_eop), 32'(mb[8]));
            end
        end
        if (parity_err && !pkt_done) check("perr_without_done", 1, 0);
        if (pkt_done) begin
            n_done++;
            if (exp_done.size() == 0) check("done_unexpected", 1, 0);
            else begin
                md = exp_done.pop_front();
                check("done_parity_err", 32'(parity_err), 32'(md[8]));
                check("done_len", 32'(pkt_len), 32'(md[7:2]));
                check("done_addr", 32'(pkt_addr), 32'(md[1:0]));
            end
        end
        if (pkt_abort) n_abort++;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Packet = header, len payload bytes, XOR parity (optionally corrupted).
    task automatic push_pkt(input logic [7:0] hdr, input logic [7:0] pl[$], input bit bad);
        logic [7:0] par;
        int len;
        len = int'(hdr[7:2]);
        par = hdr;
        fq.push_back(hdr);
        for (int i = 0; i < len; i++) begin
            par ^= pl[i];
            fq.push_back(pl[i]);
            exp_beats.push_back({(i == 0), (i == len - 1), pl[i]});
        end
        if (bad) par ^= 8'h01;
        fq.push_back(par);
        exp_done.push_back({bad & PCHK, hdr[7:2], hdr[1:0]});
        n_pushed += len + 2;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            tick();
            k++;
        end
        check("done_count", n_done, target);
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] hdr;
        int r0, b0, k, len, ndone_exp;

        reset = 1'b1;
        pl = '{8'hA1, 8'hB2, 8'hC3};
        push_pkt(8'h0D, pl, 1'b0);

        // Reset held with vld_out high: no reads, outputs cleared.
        tick();
        repeat (3) begin
            tick();
            check("rst_read_enb", 32'(rif.read_enb), 0);
            check("rst_out_valid", 32'(rif.out_valid), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_pkt_done", 32'(pkt_done), 0);
            check("rst_pkt_abort", 32'(pkt_abort), 0);
            check("rst_pkt_len", 32'(pkt_len), 0);
            check("rst_pkt_addr", 32'(pkt_addr), 0);
            check("rst_vld_high", 32'(rif.vld_out), 1);
        end
        check("rst_no_reads", n_reads, 0);
        reset = 1'b0;

        // Basic packet, addr 1 len 3
        wait_done(1, 200);
        check("pkt1_reads", n_reads, 5);
        check("pkt1_beats", beat_cyc.size(), 3);
        if (beat_cyc.size() == 3) begin
            check("pkt1_spacing0", beat_cyc[1] - beat_cyc[0], 2);
            check("pkt1_spacing1", beat_cyc[2] - beat_cyc[1], 2);
        end

        // Same packet with bad parity 0xDC
        repeat (4) tick();
        push_pkt(8'h0D, pl, 1'b1);
        wait_done(2, 200);

        // Sink stall right after the first payload beat
        repeat (4) tick();
        b0 = n_beats;
        push_pkt(8'h0D, pl, 1'b0);
        k = 0;
        while (n_beats == b0 && k < 100) begin
            tick();
            k++;
        end
        check("stall_first_beat", n_beats - b0, 1);
        sink_cmd = 1'b0;
        r0 = n_reads;
        b0 = n_beats;
        repeat (10) tick();
        check("stall_no_reads", n_reads - r0, 0);
        check("stall_extra_le1", 32'((n_beats - b0) <= 1), 1);
        check("stall_busy", 32'(busy), 1);
        sink_cmd = 1'b1;
        wait_done(3, 200);

        // Abort: FIFO flushed after the first payload byte
        repeat (4) tick();
        fq.push_back(8'h0D);
        fq.push_back(8'hA1);
        exp_beats.push_back({1'b1, 1'b0, 8'hA1});
        n_pushed += 2;
        k = 0;
        while (n_abort == 0 && k < 120) begin
            tick();
            k++;
        end
        repeat (5) tick();
        check("abort_once", n_abort, 1);
        check("abort_no_done", n_done, 3);
        check("abort_busy", 32'(busy), 0);
        check("abort_len_kept", 32'(pkt_len), 3);
        check("abort_addr_kept", 32'(pkt_addr), 1);

        // Zero-length packet: header 0x02, parity 0x02
        repeat (6) tick();
        b0 = n_beats;
        pl.delete();
        push_pkt(8'h02, pl, 1'b0);
        wait_done(4, 200);
        check("zl_start_delay", last_rd_cyc - 2 - rise_neg, START_DELAY);
        check("zl_no_beats", n_beats - b0, 0);
        check("zl_len", 32'(pkt_len), 0);
        check("zl_addr", 32'(pkt_addr), 2);

        // Randomized packets with random sink and FIFO-valid gaps
        rnd_mode = 1'b1;
        ndone_exp = 4;
        for (int p = 0; p < 30; p++) begin
            len = $urandom_range(0, 12);
            hdr = {6'(len), 2'($urandom_range(0, 3))};
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
            push_pkt(hdr, pl, ($urandom_range(0, 3) == 0));
            ndone_exp++;
            if ($urandom_range(0, 1) == 1) wait_done(ndone_exp, 3000);
        end
        wait_done(ndone_exp, 20000);
        rnd_mode = 1'b0;
        repeat (5) tick();

        check("end_beats_drained", exp_beats.size(), 0);
        check("end_done_drained", exp_done.size(), 0);
        check("end_reads_total", n_reads, n_pushed);
        check("end_abort_total", n_abort, 1);
        check("end_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/router_dest_reader.md
Name: router_dest_reader

Overview:
Destination-side drain engine for one router output port; it is the reader for the per-port FIFO that the write-side synchronizer fills.
- Watches the FIFO's vld_out and issues read_enb in time to avoid the 30-cycle soft-reset timeout.
- Parses the packet: header, then payload, then parity.
- Streams payload bytes to the destination with SOP/EOP marking and checks parity.
- One instance per output port (0/1/2).

Parameters:
START_DELAY, 2, cycles vld_out must be continuously high in IDLE before the header read is issued; legal range 0..27.
ABORT_TIMEOUT, 31, consecutive cycles mid-packet with vld_out low before the packet is aborted; legal range 1..31, 5-bit counter.

Ports:
clock  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
vld_out  input  1  FIFO not-empty
data_out  input  8  FIFO read data, valid exactly 1 cycle after read_enb sampled high
sink_ready  input  1  destination can accept bytes; sampled only when issuing a read
read_enb  output  1  FIFO read strobe
out_data  output  8  payload byte to destination
out_valid  output  1  out_data valid, one-cycle pulse per byte
out_sop  output  1  high with first payload beat
out_eop  output  1  high with last payload beat
pkt_addr  output  2  header[1:0] of current/last packet, held until next header
pkt_len  output  6  header[7:2] of current/last packet, held until next header
pkt_done  output  1  one-cycle pulse after parity byte consumed
parity_err  output  1  one-cycle pulse coincident with pkt_done when parity mismatches
pkt_abort  output  1  one-cycle pulse on timeout abort
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, checked first, every cycle):
  - FSM goes to IDLE.
  - All outputs 0: pkt_addr=0, pkt_len=0; counters, parity accumulator and in-flight flag cleared.
  - Reset mid-packet discards the packet with no pkt_done and no pkt_abort.
- Packet format:
  - Byte 0 is the header: len=[7:2] (0..63), addr=[1:0].
  - Then len payload bytes.
  - Then 1 parity byte equal to the XOR of the header and all payload bytes.
- Read pacing: at most one read in flight. read_enb is never high in two consecutive cycles. rd_inflight is set the cycle after read_enb and cleared when data is captured.
- FSM states: IDLE, HEADER, PAYLOAD, PARITY.
  - IDLE: wait counter increments while vld_out=1 and clears when vld_out=0. When count==START_DELAY and vld_out=1, assert read_enb and go to HEADER. sink_ready is ignored here.
  - HEADER: capture data_out in the cycle after read_enb.
    - Load pkt_len and pkt_addr; acc=header; rx_cnt=0.
    - len==0 goes to PARITY; otherwise go to PAYLOAD.
  - PAYLOAD: read_enb = vld_out & sink_ready & ~rd_inflight & (issued<len).
    - Each captured byte is registered to out_data with out_valid=1 in the following cycle (read_enb at t gives out_valid at t+2).
    - acc ^= byte and rx_cnt++.
    - out_sop when rx_cnt==0; out_eop when rx_cnt==len-1.
    - After the eop byte is captured, go to PARITY.
  - PARITY: issue one read when vld_out & ~rd_inflight (sink_ready ignored) and capture the byte.
    - The next cycle pulses pkt_done; parity_err=(acc!=byte) under the macro.
    - Then return to IDLE, wait counter cleared.
- Downstream slack: a byte already in flight when sink_ready falls is still presented. The destination must absorb one beat after deasserting sink_ready.
- Abort: in HEADER/PAYLOAD/PARITY, a timeout counter counts cycles with vld_out=0 and no read in flight, and clears on any capture.
  - When it reaches ABORT_TIMEOUT: pulse pkt_abort, go to IDLE.
  - No pkt_done and no eop are emitted. pkt_len/pkt_addr are retained.
  - This covers the case where the FIFO was soft-reset and flushed.
- Simultaneous events:
  - vld_out falling in the same cycle as read_enb: the read is still counted as issued and data is captured next cycle.
  - pkt_done and a new header read are never in the same cycle; the minimum gap is 1 IDLE cycle plus START_DELAY.

Optional Feature:
ROUTER_PARITY_CHK_EN
- Defined: the parity byte is compared against the accumulator and parity_err pulses with pkt_done on mismatch.
- Undefined: the parity byte is still read and discarded, the accumulator is not synthesized, and parity_err is tied to 0.

Test Plan:
- Assert reset for 3 cycles with vld_out=1 -> read_enb, out_valid, busy, pkt_done, pkt_abort, pkt_len, pkt_addr all 0; no read during reset.
- FIFO holds 0x0D,0xA1,0xB2,0xC3,0xDD; sink_ready=1 -> pkt_len=3, pkt_addr=1; out_data A1(sop),B2,C3(eop) at 2-cycle spacing; pkt_done=1, parity_err=0; total 5 read_enb pulses.
- Same packet with parity 0xDC -> parity_err=1 with pkt_done when the macro is defined; 0 when undefined.
- sink_ready low for 10 cycles after the first payload beat -> read_enb stays 0, at most 1 extra out_valid; on resume B2,C3 delivered in order, no byte lost or duplicated.
- vld_out drops after payload byte 1 and stays low 31 cycles -> pkt_abort pulses once, busy=0, no out_eop, no pkt_done.
- vld_out rises at cycle 0 with header 0x02, parity 0x02 -> first read_enb at cycle START_DELAY (2); pkt_len=0, pkt_addr=2; no out_valid; pkt_done=1, parity_err=0.
